// File: rtl/denoise_window_sequencer_if.sv
// -----------------------------------------------------------------------------
// denoise_window_sequencer_if
// Groups the pixel-stream handshake, the window bus towards the denoising core
// and the frame status lines of denoise_window_sequencer.
//
// Signals:
//   iStart       frame start request (source -> sequencer)
//   iPixValid    input pixel valid
//   iv8Pixel     input pixel, raster order
//   oPixReady    sequencer can accept a pixel this cycle
//   oDataValid   single-cycle window strobe
//   ov8Pixel_*   3x3 neighbourhood, a/b/c top, d/fij/e middle, f/g/h bottom
//   ovRow/ovCol  centre coordinate of the current window
//   oBusy        frame in progress
//   oFrameDone   one-cycle pulse after the last window
//
// Modports:
//   master  pixel source / frame controller side
//   slave   sequencer side
// -----------------------------------------------------------------------------
interface denoise_window_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             iStart;
  logic             iPixValid;
  logic [7:0]       iv8Pixel;
  logic             oPixReady;
  logic             oDataValid;
  logic [7:0]       ov8Pixel_a;
  logic [7:0]       ov8Pixel_b;
  logic [7:0]       ov8Pixel_c;
  logic [7:0]       ov8Pixel_d;
  logic [7:0]       ov8Pixel_fij;
  logic [7:0]       ov8Pixel_e;
  logic [7:0]       ov8Pixel_f;
  logic [7:0]       ov8Pixel_g;
  logic [7:0]       ov8Pixel_h;
  logic [CNT_W-1:0] ovRow;
  logic [CNT_W-1:0] ovCol;
  logic             oBusy;
  logic             oFrameDone;

  modport master (
    output iStart, iPixValid, iv8Pixel,
    input  oPixReady, oDataValid,
    input  ov8Pixel_a, ov8Pixel_b, ov8Pixel_c,
    input  ov8Pixel_d, ov8Pixel_fij, ov8Pixel_e,
    input  ov8Pixel_f, ov8Pixel_g, ov8Pixel_h,
    input  ovRow, ovCol, oBusy, oFrameDone
  );

  modport slave (
    input  iStart, iPixValid, iv8Pixel,
    output oPixReady, oDataValid,
    output ov8Pixel_a, ov8Pixel_b, ov8Pixel_c,
    output ov8Pixel_d, ov8Pixel_fij, ov8Pixel_e,
    output ov8Pixel_f, ov8Pixel_g, ov8Pixel_h,
    output ovRow, ovCol, oBusy, oFrameDone
  );
endinterface

// File: rtl/denoise_window_sequencer.sv
// -----------------------------------------------------------------------------
// denoise_window_sequencer
// Frame-level controller in front of the decision-tree denoising core. Takes a
// raster pixel stream (valid/ready), keeps the last 2*IMG_W+3 pixels in a
// circular buffer and issues one registered 3x3 neighbourhood plus a
// single-cycle strobe per frame position, with border clamping and flush.
//
// Ports:
//   iClk   clock, rising edge
//   iRst   asynchronous active-low reset
//   bus    denoise_window_sequencer_if.slave (stream in, window out, status)
//
// Optional feature macro: BORDER_ZERO_EN
//   defined   -> out-of-frame neighbours are driven as 0
//   undefined -> out-of-frame neighbours replicate the nearest edge pixel
// -----------------------------------------------------------------------------
module denoise_window_sequencer #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CNT_W = 16
) (
  input  logic                        iClk,
  input  logic                        iRst,
  denoise_window_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int DEPTH = 2 * IMG_W + 3;
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = $clog2(3 * DEPTH) + 1;

  localparam logic [CNT_W-1:0] TOTAL_C   = CNT_W'(TOTAL);
  localparam logic [CNT_W:0]   TOTAL_X   = (CNT_W + 1)'(TOTAL);
  localparam logic [CNT_W:0]   LOOKAHEAD = (CNT_W + 1)'(IMG_W + 2);
  localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(IMG_H - 1);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);

  typedef logic [AW-1:0] addr_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  addr_t            ctr_ptr_q, ctr_ptr_d;
  addr_t            wr_ptr_q, wr_ptr_d;
  logic             data_valid_q, data_valid_d;
  logic [7:0]       win_q [9];
  logic [7:0]       win_d [9];
  logic [CNT_W-1:0] win_row_q, win_row_d;
  logic [CNT_W-1:0] win_col_q, win_col_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [7:0]       pix_mem_q [DEPTH];
  logic [7:0]       tap [9];

  logic             pix_ready;
  logic             accept;
  logic             issue;
  logic [CNT_W:0]   in_next;
  logic [CNT_W:0]   need;
  logic [CNT_W:0]   limit;
  logic             at_top, at_bot, at_left, at_right;
  logic [SW-1:0]    row_ofs [3];
  logic [SW-1:0]    ofs;
  addr_t            taddr;

  // Neighbour offsets are pre-biased by DEPTH so they stay non-negative;
  // the sum is then folded back into [0, DEPTH) with at most two subtracts.
  function automatic addr_t wrap_add(input addr_t base, input logic [SW-1:0] o);
    logic [SW-1:0] s;
    s = SW'(base) + o;
    if (s >= SW'(2 * DEPTH)) begin
      s = s - SW'(2 * DEPTH);
    end else if (s >= SW'(DEPTH)) begin
      s = s - SW'(DEPTH);
    end
    return addr_t'(s);
  endfunction

  // Lookahead of IMG_W+2 pixels caps occupancy at 2*IMG_W+3 entries, so the
  // slot being written never holds a pixel still needed by a pending window.
  assign pix_ready = (state_q == S_RUN) && (in_cnt_q < TOTAL_C) &&
                     ({1'b0, in_cnt_q} < ({1'b0, out_cnt_q} + LOOKAHEAD));
  assign accept    = bus.iPixValid & pix_ready;

  // Window k needs pixels up to k+IMG_W+1, or the whole frame near the end.
  // The count includes a pixel accepted this cycle, which is bypassed below.
  always_comb begin
    in_next = {1'b0, in_cnt_q} + (CNT_W + 1)'(accept);
    need    = {1'b0, out_cnt_q} + LOOKAHEAD;
    limit   = (need > TOTAL_X) ? TOTAL_X : need;
    issue   = (state_q == S_RUN) && (out_cnt_q < TOTAL_C) && (in_next >= limit);
  end

  // Gather the nine taps around the next window centre. Clamping collapses
  // the offset to the centre row/column; a tap that lands on the slot being
  // written this cycle takes the incoming pixel directly.
  always_comb begin
    at_top     = (row_q == '0);
    at_bot     = (row_q == LAST_ROW);
    at_left    = (col_q == '0);
    at_right   = (col_q == LAST_COL);
    row_ofs[0] = at_top ? SW'(DEPTH) : SW'(DEPTH - IMG_W);
    row_ofs[1] = SW'(DEPTH);
    row_ofs[2] = at_bot ? SW'(DEPTH) : SW'(DEPTH + IMG_W);
    ofs        = '0;
    taddr      = '0;
    for (int v = 0; v < 3; v++) begin
      for (int h = 0; h < 3; h++) begin
        ofs = row_ofs[v];
        if (h == 0 && !at_left) begin
          ofs = ofs - SW'(1);
        end
        if (h == 2 && !at_right) begin
          ofs = ofs + SW'(1);
        end
        taddr = wrap_add(ctr_ptr_q, ofs);
        if (accept && (taddr == wr_ptr_q)) begin
          tap[v*3+h] = bus.iv8Pixel;
        end else begin
          tap[v*3+h] = pix_mem_q[taddr];
        end
`ifdef BORDER_ZERO_EN
        if ((v == 0 && at_top) || (v == 2 && at_bot) ||
            (h == 0 && at_left) || (h == 2 && at_right)) begin
          tap[v*3+h] = 8'd0;
        end
`endif
      end
    end
  end

  // Next-state logic for the frame FSM, counters and registered outputs.
  // The cycle after the last window sees out_cnt == TOTAL and moves to DONE,
  // so oFrameDone trails the final strobe by one cycle.
  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    ctr_ptr_d    = ctr_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    data_valid_d = 1'b0;
    win_d        = win_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          state_d   = S_RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          row_d     = '0;
          col_d     = '0;
          ctr_ptr_d = '0;
          wr_ptr_d  = '0;
          busy_d    = 1'b1;
        end
      end
      S_RUN: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);
        end
        if (issue) begin
          data_valid_d = 1'b1;
          win_d        = tap;
          win_row_d    = row_q;
          win_col_d    = col_q;
          out_cnt_d    = out_cnt_q + CNT_W'(1);
          ctr_ptr_d    = (ctr_ptr_q == LAST_ADDR) ? '0 : ctr_ptr_q + AW'(1);
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + CNT_W'(1);
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
        if (out_cnt_q == TOTAL_C) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q      <= S_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      ctr_ptr_q    <= '0;
      wr_ptr_q     <= '0;
      data_valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= 8'd0;
      end
      win_row_q    <= '0;
      win_col_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      ctr_ptr_q    <= ctr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      data_valid_q <= data_valid_d;
      win_q        <= win_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Pixel buffer; contents are don't-care after reset.
  always_ff @(posedge iClk) begin
    if (accept) begin
      pix_mem_q[wr_ptr_q] <= bus.iv8Pixel;
    end
  end

  assign bus.oPixReady    = pix_ready;
  assign bus.oDataValid   = data_valid_q;
  assign bus.ov8Pixel_a   = win_q[0];
  assign bus.ov8Pixel_b   = win_q[1];
  assign bus.ov8Pixel_c   = win_q[2];
  assign bus.ov8Pixel_d   = win_q[3];
  assign bus.ov8Pixel_fij = win_q[4];
  assign bus.ov8Pixel_e   = win_q[5];
  assign bus.ov8Pixel_f   = win_q[6];
  assign bus.ov8Pixel_g   = win_q[7];
  assign bus.ov8Pixel_h   = win_q[8];
  assign bus.ovRow        = win_row_q;
  assign bus.ovCol        = win_col_q;
  assign bus.oBusy        = busy_q;
  assign bus.oFrameDone   = done_q;

endmodule

// File: doc/denoise_window_sequencer.md
Name: denoise_window_sequencer

Overview:
- Frame-level controller that feeds the decision-tree denoising core.
- Accepts a raster pixel stream with a valid/ready handshake and buffers two lines plus a few pixels.
- For every frame position, issues one 3x3 neighbourhood and a single-cycle data-valid strobe to the core.
- Handles frame start/end, border clamping and input back-pressure; reports busy and frame-done status.

Parameters:
- IMG_W, 64, pixels per line (>=3).
- IMG_H, 64, lines per frame (>=3).
- CNT_W, 16, width of row/column/index counters; must satisfy 2^CNT_W > IMG_W*IMG_H.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iRst  in  1  reset, asynchronous, active-low.
- iStart  in  1  single-cycle frame start request; honoured only in IDLE.
- iPixValid  in  1  input pixel valid.
- iv8Pixel  in  8  input pixel, raster order.
- oPixReady  out  1  sequencer can accept a pixel this cycle.
- oDataValid  out  1  window strobe to the core's data-valid input.
- ov8Pixel_a, ov8Pixel_b, ov8Pixel_c  out  8 each  window top row: (r-1,c-1), (r-1,c), (r-1,c+1).
- ov8Pixel_d, ov8Pixel_fij, ov8Pixel_e  out  8 each  window middle row: (r,c-1), centre (r,c), (r,c+1).
- ov8Pixel_f, ov8Pixel_g, ov8Pixel_h  out  8 each  window bottom row: (r+1,c-1), (r+1,c), (r+1,c+1).
- ovRow, ovCol  out  CNT_W each  centre coordinate of the current window.
- oBusy  out  1  high in RUN.
- oFrameDone  out  1  one-cycle pulse after the last window is issued.

Behaviour:
- Reset values (iRst low, immediate): all outputs 0, state IDLE, all counters 0, buffer contents don't-care.
- FSM states:
  - IDLE: oPixReady=0. iStart=1 clears counters and moves to RUN next cycle.
  - RUN: active frame; iStart is ignored.
  - DONE: one cycle with oFrameDone=1, then IDLE.
- Counters: in_cnt = pixels accepted; out_cnt = windows issued (k = r*IMG_W + c).
- Accept: a pixel is accepted on a cycle where iPixValid & oPixReady.
- oPixReady (combinational) = RUN & in_cnt < IMG_W*IMG_H & in_cnt < out_cnt + IMG_W + 2.
  - This bounds storage to 2*IMG_W+3 pixels.
- Issue rule: window k is issuable when in_cnt >= min(k + IMG_W + 2, IMG_W*IMG_H).
  - in_cnt here includes a pixel accepted in the same cycle.
  - Outputs are registered: oDataValid is high the cycle after the condition holds.
- Throughput and steady-state timing:
  - Maximum one window per cycle.
  - Latency from accepting pixel k+IMG_W+1 to window k strobe is 1 cycle.
- Flush: after the last pixel is accepted, the remaining IMG_W+1 windows issue on consecutive cycles with no further input.
- Border handling (replicate): coordinates are clamped into [0,IMG_W-1] x [0,IMG_H-1], so out-of-frame neighbours take the nearest edge pixel.
  - Corner example: window (0,0) has a=b=d=fij.
- Output hold: between strobes, oDataValid=0 and the window/coordinate outputs hold their last value.
- Frame end: after window IMG_W*IMG_H-1 issues, RUN -> DONE -> IDLE.
  - oBusy drops in the same cycle oFrameDone rises.
- Simultaneous events: iStart while in RUN or DONE has no effect.
  - iPixValid while oPixReady=0 leaves the pixel unconsumed; the source holds it.
- Reset mid-frame: abandons the frame immediately; no oFrameDone. A new iStart is required.
- Arithmetic: counters are unsigned CNT_W bits; the min/compare logic must not wrap for legal parameters.

Optional Feature:
- Macro: BORDER_ZERO_EN.
- Defined: out-of-frame neighbours are driven as 8'd0 instead of replicated edge pixels.
  - Centre pixel and in-frame neighbours are unchanged.
  - Timing is identical to the undefined case.
- Undefined: edge replication as specified in Behaviour.

Test Plan:
- Reset/idle (IMG_W=4, IMG_H=3): hold iRst low, then release -> all outputs 0; oPixReady=0 until iStart.
- Full-rate frame (IMG_W=4, IMG_H=3): iStart, then 12 pixels valued 10..21 back-to-back.
  - -> First strobe one cycle after pixel 15 (the 6th) is accepted; window (0,0) is a=b=d=fij=10, c=e=11, f=g=14, h=15.
  - -> 12 strobes total, the last 5 during flush; oFrameDone 1 cycle after the last strobe.
- Back-pressure (IMG_W=4, IMG_H=3): iPixValid held high continuously -> oPixReady never allows in_cnt > out_cnt+6; no pixel is lost or duplicated.
  - Check: window (1,1) centre = 15, a=10, h=20.
- Bottom-right corner (IMG_W=4, IMG_H=3): window (2,3) -> fij=e=g=h=21, a=16, b=c=17, d=f=20.
  - Same frame with BORDER_ZERO_EN defined -> c, e, f, g, h = 0.
- Gapped input: iPixValid toggled every other cycle -> every window matches the full-rate case; ovRow/ovCol sequence (0,0)..(2,3) in order.
- Mid-frame reset: assert iRst after 7 pixels -> outputs 0 at once, no oFrameDone.
  - A following iStart plus a full frame completes normally with a correct first window.
